// File: rtl/pll_ctrl_pkg.sv
// Shared encodings for the PLL lock sequencer: state values and status field widths.
// The state encoding is software-visible through the status register, so values are fixed.
package pll_ctrl_pkg;

    localparam int STATE_W    = 3;
    localparam int LOST_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD_RST  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_READY     = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with asynchronous active-high reset to 0.
// Suitable for any slow level signal crossing into the clk_i domain.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer running on the reference clock: holds the PLL in reset,
// waits for lock with bounded retries, qualifies lock stability and watches for loss.
module pll_lock_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES          = 1000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 4096,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 20
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic                  pll_ready,
    output logic                  fault,
    output logic [STATE_W-1:0]    state,
    output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

    localparam int RETRY_W = 4;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    pll_state_e            state_q, state_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [LOST_CNT_W-1:0] lost_q, lost_d;
    logic                  restart;
    logic                  lock_s;

    sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HOLD_RST;
            timer_q <= '0;
            retry_q <= '0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            lost_q  <= lost_d;
        end
    end

    // In READY a lock loss outranks relock_req so the loss is always counted.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        restart = 1'b0;
        unique case (state_q)
            ST_HOLD_RST: begin
                if (relock_req) begin
                    restart = 1'b1;
                    retry_d = '0;
                end else if (timer_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (relock_req) begin
                    state_d = ST_HOLD_RST;
                    retry_d = '0;
                end else if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = (retry_d == RETRY_LIMIT) ? ST_FAULT : ST_HOLD_RST;
                end
            end
            ST_STABLE: begin
                if (relock_req) begin
                    state_d = ST_HOLD_RST;
                    retry_d = '0;
                end else if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = ST_READY;
                    retry_d = '0;
                end
            end
            ST_READY: begin
                if (!lock_s) begin
                    state_d = ST_HOLD_RST;
                    if (lost_q != '1) begin
                        lost_d = lost_q + LOST_CNT_W'(1);
                    end
                end else if (relock_req) begin
                    state_d = ST_HOLD_RST;
                    retry_d = '0;
                end
            end
            ST_FAULT: begin
                if (relock_req) begin
                    state_d = ST_HOLD_RST;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_HOLD_RST;
                retry_d = '0;
            end
        endcase
        timer_d = (restart || (state_d != state_q)) ? '0 : timer_q + CNT_W'(1);
    end

    assign pll_rst       = (state_q == ST_HOLD_RST) || (state_q == ST_FAULT);
    assign pll_ready     = (state_q == ST_READY);
    assign fault         = (state_q == ST_FAULT);
    assign state         = state_q;
    assign lock_lost_cnt = lost_q;

endmodule
